// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared types, constants and counter helper for the branch predictor
package branch_pred_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bp_state_e;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic ctr_t ctr_sat_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end else begin
      return (c == 2'b00) ? c : c - 2'd1;
    end
  endfunction

endpackage

// File: rtl/bht_counter_table.sv
// rtl/bht_counter_table.sv - table of 2-bit saturating counters, one read port and one update port
module bht_counter_table
  import branch_pred_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_rd_pc,
  output ctr_t            o_rd_ctr,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  ctr_t             r_ctr [ENTRIES];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_unused_pc_bits;

  assign w_rd_idx  = i_rd_pc[IDX_W+1:2];
  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{i_rd_pc[XLEN-1:IDX_W+2], i_rd_pc[1:0],
                              i_upd_pc[XLEN-1:IDX_W+2], i_upd_pc[1:0]};

  // Read is purely combinational, so a same-cycle update is not visible until the next cycle.
  assign o_rd_ctr = r_ctr[w_rd_idx];

  // Counter storage: reset to weakly not-taken, otherwise saturating step on update.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_RESET;
      end
    end else if (i_upd_en) begin
      r_ctr[w_upd_idx] <= ctr_sat_next(r_ctr[w_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// rtl/branch_pred_ctrl.sv - branch predictor control: run/flush FSM, redirect, optional BHT (BRANCH_PRED_BHT_EN)
module branch_pred_ctrl
  import branch_pred_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_fetch_valid,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_pred_taken,
  input  logic            i_ex_valid,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_is_jump,
  input  logic            i_ex_taken,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_target,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush
);

  bp_state_e       r_state;
  bp_state_e       w_next_state;
  logic [2:0]      r_flush_cnt;
  logic [2:0]      w_flush_cnt_next;
  logic            w_mispredict;
  logic [XLEN-1:0] w_redirect_target;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  // ex_* inputs only matter while running; anything arriving during a flush is a squashed slot.
  assign w_mispredict = i_ex_valid && (r_state == ST_RUN) &&
                        ((i_ex_is_branch && (i_ex_taken != i_ex_pred_taken)) || i_ex_is_jump);

  assign w_redirect_target = (i_ex_is_jump || i_ex_taken) ? i_ex_target : i_ex_pc + XLEN'(4);

`ifdef BRANCH_PRED_BHT_EN
  ctr_t w_fetch_ctr;
  logic w_bht_upd;

  assign w_bht_upd = i_ex_valid && i_ex_is_branch && (r_state == ST_RUN);

  bht_counter_table #(
    .XLEN    (XLEN),
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rd_pc     (i_fetch_pc),
    .o_rd_ctr    (w_fetch_ctr),
    .i_upd_en    (w_bht_upd),
    .i_upd_pc    (i_ex_pc),
    .i_upd_taken (i_ex_taken)
  );

  assign o_pred_taken = i_fetch_valid & w_fetch_ctr[1];
`else
  logic w_unused_fetch;

  // Static not-taken: upstream then carries pred=0, so every taken branch mispredicts.
  assign w_unused_fetch = ^{i_fetch_valid, i_fetch_pc};
  assign o_pred_taken   = 1'b0;
`endif

  // State and flush-counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Next state: a mispredict opens a flush of FLUSH_CYCLES cycles, counted down to 0.
  always_comb begin
    w_next_state     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mispredict) begin
          w_next_state     = ST_FLUSH;
          w_flush_cnt_next = 3'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == 3'd0) begin
          w_next_state = ST_RUN;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 3'd1;
        end
      end
      default: begin
        w_next_state     = ST_RUN;
        w_flush_cnt_next = 3'd0;
      end
    endcase
  end

  // Redirect pulse on the first flush cycle; the target is held until the next redirect.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= w_redirect_target;
      end
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_flush          = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb/tb_branch_pred_ctrl.sv - directed self-checking bench for branch_pred_ctrl and bht_counter_table
module tb_branch_pred_ctrl;

`ifdef BRANCH_PRED_BHT_EN
  localparam logic BHT = 1'b1;
`else
  localparam logic BHT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        rv;
  logic [31:0] rpc;
  logic        flush;

  logic [31:0] t_rd_pc;
  logic [1:0]  t_rd_ctr;
  logic        t_upd_en;
  logic [31:0] t_upd_pc;
  logic        t_upd_taken;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pred_ctrl #(
    .XLEN         (32),
    .BHT_ENTRIES  (16),
    .FLUSH_CYCLES (2)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_fetch_valid    (fetch_valid),
    .i_fetch_pc       (fetch_pc),
    .o_pred_taken     (pred),
    .i_ex_valid       (ex_valid),
    .i_ex_is_branch   (ex_is_branch),
    .i_ex_is_jump     (ex_is_jump),
    .i_ex_taken       (ex_taken),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pc          (ex_pc),
    .i_ex_target      (ex_target),
    .o_redirect_valid (rv),
    .o_redirect_pc    (rpc),
    .o_flush          (flush)
  );

  bht_counter_table #(
    .XLEN    (32),
    .ENTRIES (16)
  ) tbl (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_rd_pc     (t_rd_pc),
    .o_rd_ctr    (t_rd_ctr),
    .i_upd_en    (t_upd_en),
    .i_upd_pc    (t_upd_pc),
    .i_upd_taken (t_upd_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle;
    ex_valid      = 1'b0;
    ex_is_branch  = 1'b0;
    ex_is_jump    = 1'b0;
    ex_taken      = 1'b0;
    ex_pred_taken = 1'b0;
  endtask

  task automatic ex_br(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic pr);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_is_jump    = 1'b0;
    ex_taken      = tk;
    ex_pred_taken = pr;
    ex_pc         = pc;
    ex_target     = tgt;
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0;
    fetch_pc = 32'h0;
    ex_pc = 32'h0;
    ex_target = 32'h0;
    ex_idle();
    t_rd_pc = 32'h0;
    t_upd_en = 1'b0;
    t_upd_pc = 32'h0;
    t_upd_taken = 1'b0;
    tick();
    tick();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_valid", {31'd0, rv}, 32'd0);
    chk("rst_redirect_pc", rpc, 32'h0);
    rst = 1'b0;

    fetch_valid = 1'b1;
    fetch_pc = 32'h40;
    #1;
    chk("pred_0x40_after_reset", {31'd0, pred}, 32'd0);

    // Counter table on its own
    t_rd_pc = 32'h40;
    #1;
    chk("tbl_reset_01", {30'd0, t_rd_ctr}, 32'd1);
    t_upd_en = 1'b1;
    t_upd_pc = 32'h40;
    t_upd_taken = 1'b1;
    #1;
    chk("tbl_same_idx_old", {30'd0, t_rd_ctr}, 32'd1);
    tick();
    chk("tbl_inc_to_2", {30'd0, t_rd_ctr}, 32'd2);
    tick();
    chk("tbl_inc_to_3", {30'd0, t_rd_ctr}, 32'd3);
    tick();
    chk("tbl_sat_3", {30'd0, t_rd_ctr}, 32'd3);
    t_upd_en = 1'b0;
    t_rd_pc = 32'h80;
    #1;
    chk("tbl_alias_0x80", {30'd0, t_rd_ctr}, 32'd3);
    t_rd_pc = 32'h44;
    #1;
    chk("tbl_0x44_untouched", {30'd0, t_rd_ctr}, 32'd1);
    t_upd_en = 1'b1;
    t_upd_pc = 32'h44;
    t_upd_taken = 1'b0;
    tick();
    chk("tbl_dec_to_0", {30'd0, t_rd_ctr}, 32'd0);
    tick();
    chk("tbl_sat_0", {30'd0, t_rd_ctr}, 32'd0);
    t_upd_en = 1'b0;

    // Train branch at 0x40 twice, correctly predicted (no redirect)
    ex_br(32'h40, 32'h300, 1'b1, 1'b1);
    fetch_pc = 32'h40;
    #1;
    chk("pred_same_idx_old", {31'd0, pred}, 32'd0);
    tick();
    tick();
    ex_idle();
    #1;
    chk("pred_0x40_trained", {31'd0, pred}, {31'd0, BHT});
    fetch_pc = 32'h80;
    #1;
    chk("pred_0x80_alias", {31'd0, pred}, {31'd0, BHT});
    chk("no_redirect_on_hit", {31'd0, rv}, 32'd0);
    chk("no_flush_on_hit", {31'd0, flush}, 32'd0);

    // Taken branch predicted not-taken at 0x100
    ex_br(32'h100, 32'h200, 1'b1, 1'b0);
    tick();
    ex_idle();
    chk("mp_redirect_valid", {31'd0, rv}, 32'd1);
    chk("mp_redirect_pc", rpc, 32'h200);
    chk("mp_flush_c1", {31'd0, flush}, 32'd1);
    tick();
    chk("mp_redirect_valid_c2", {31'd0, rv}, 32'd0);
    chk("mp_flush_c2", {31'd0, flush}, 32'd1);
    chk("mp_redirect_pc_hold", rpc, 32'h200);
    tick();
    chk("mp_flush_done", {31'd0, flush}, 32'd0);

    // Not-taken branch at top of address space: fall-through wraps to 0
    ex_br(32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1);
    tick();
    ex_idle();
    chk("wrap_redirect_valid", {31'd0, rv}, 32'd1);
    chk("wrap_redirect_pc", rpc, 32'h0);
    tick();
    tick();
    chk("wrap_flush_done", {31'd0, flush}, 32'd0);

    // jal at 0x20: always redirects, never trains
    ex_valid = 1'b1;
    ex_is_branch = 1'b0;
    ex_is_jump = 1'b1;
    ex_taken = 1'b1;
    ex_pred_taken = 1'b1;
    ex_pc = 32'h20;
    ex_target = 32'h80;
    tick();
    ex_idle();
    chk("jal_redirect_valid", {31'd0, rv}, 32'd1);
    chk("jal_redirect_pc", rpc, 32'h80);
    tick();
    tick();
    fetch_pc = 32'h20;
    #1;
    chk("jal_no_update", {31'd0, pred}, 32'd0);

    // Second mispredict in first flush cycle is squashed
    ex_br(32'h44, 32'h400, 1'b1, 1'b0);
    tick();
    chk("sq_first_redirect", {31'd0, rv}, 32'd1);
    chk("sq_first_pc", rpc, 32'h400);
    ex_br(32'h48, 32'h500, 1'b1, 1'b0);
    tick();
    ex_idle();
    chk("sq_no_second_redirect", {31'd0, rv}, 32'd0);
    chk("sq_pc_held", rpc, 32'h400);
    chk("sq_flush_c2", {31'd0, flush}, 32'd1);
    tick();
    chk("sq_flush_done", {31'd0, flush}, 32'd0);
    fetch_pc = 32'h48;
    #1;
    chk("sq_counter_unchanged", {31'd0, pred}, 32'd0);
    fetch_pc = 32'h44;
    #1;
    chk("sq_first_trained", {31'd0, pred}, {31'd0, BHT});

    // Reset in second flush cycle
    ex_br(32'h4C, 32'h600, 1'b1, 1'b0);
    tick();
    ex_idle();
    chk("rf_redirect", {31'd0, rv}, 32'd1);
    tick();
    chk("rf_flush_c2", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rf_flush_low", {31'd0, flush}, 32'd0);
    chk("rf_redirect_valid_low", {31'd0, rv}, 32'd0);
    chk("rf_redirect_pc_zero", rpc, 32'h0);
    fetch_pc = 32'h40;
    t_rd_pc = 32'h40;
    #1;
    chk("rf_pred_0x40_reset", {31'd0, pred}, 32'd0);
    chk("rf_tbl_0x40_01", {30'd0, t_rd_ctr}, 32'd1);
    t_rd_pc = 32'h44;
    #1;
    chk("rf_tbl_0x44_01", {30'd0, t_rd_ctr}, 32'd1);
    fetch_pc = 32'h4C;
    #1;
    chk("rf_pred_0x4c_reset", {31'd0, pred}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rf_flush_stays_low", {31'd0, flush}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC/target width.
REQ-002 The block SHALL have parameter BHT_ENTRIES, default 16 (power of 2), giving the number of predictor counters.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2 (range 1..7), giving the flush duration after a redirect.
REQ-004 The block SHALL have port clock  input  1  rising-edge clock.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port fetch_valid  input  1  fetch stage holds a valid PC.
REQ-007 The block SHALL have port fetch_pc  input  XLEN  PC being fetched.
REQ-008 The block SHALL have port pred_taken  output  1  prediction for fetch_pc (combinational).
REQ-009 The block SHALL have port ex_valid  input  1  execute stage holds a valid, unsquashed instruction.
REQ-010 The block SHALL have ports ex_is_branch and ex_is_jump  input  1 each  conditional branch (beq/bne) and jal/jalr respectively.
REQ-011 The block SHALL have ports ex_taken and ex_pred_taken  input  1 each  resolved outcome and the prediction carried down the pipe.
REQ-012 The block SHALL have ports ex_pc and ex_target  input  XLEN each  instruction PC and resolved target.
REQ-013 The block SHALL have ports redirect_valid  output  1, redirect_pc  output  XLEN, and flush  output  1.

Function
REQ-014 Index SHALL be pc[log2(BHT_ENTRIES)+1:2]; each entry is a 2-bit saturating counter.
REQ-015 pred_taken SHALL equal fetch_valid AND counter[idx(fetch_pc)][1]; zero added latency.
REQ-016 On a clock edge with ex_valid, ex_is_branch, and state RUN, counter[idx(ex_pc)] SHALL increment (saturating at 3) if ex_taken, else decrement (saturating at 0).
REQ-017 A mispredict SHALL be: ex_valid AND state RUN AND ((ex_is_branch AND ex_taken != ex_pred_taken) OR ex_is_jump).
REQ-018 The FSM SHALL have states RUN and FLUSH; a mispredict in RUN moves to FLUSH, loads the flush counter with FLUSH_CYCLES-1, and returns to RUN when the counter reaches 0.
REQ-019 redirect_valid SHALL be high for exactly the first FLUSH cycle, registered on the mispredict edge.
REQ-020 redirect_pc SHALL be ex_target if (ex_is_jump OR ex_taken), else ex_pc+4 (modulo 2^XLEN); it holds until the next redirect.
REQ-021 flush SHALL be high in every FLUSH cycle (exactly FLUSH_CYCLES cycles); in FLUSH, ex_* inputs are ignored (no update, no mispredict).
REQ-022 When a fetch read and an update hit the same index in one cycle, the read SHALL return the pre-update value.
REQ-023 Back-to-back mispredicts SHALL be impossible; the second is squashed by REQ-021.

Reset
REQ-024 In any cycle with reset high, the state SHALL go to RUN, the flush counter to 0, every counter to 2'b01 (weakly not-taken), redirect_valid to 0, and redirect_pc to 0.
REQ-025 A reset asserted mid-FLUSH SHALL abort the flush; flush SHALL be low in the cycle after reset.

Configuration
REQ-026 With macro BRANCH_PRED_BHT_EN defined, the counter table and REQ-014..016 SHALL be present.
REQ-027 Without BRANCH_PRED_BHT_EN, no counter storage SHALL exist, pred_taken SHALL be constant 0 (static not-taken), and every taken branch SHALL mispredict.

Structure
REQ-028 The package branch_pred_pkg SHALL hold the FSM state enum, the 2-bit counter typedef, the CTR_RESET constant (2'b01), and the beq/bne/jal/jalr opcode constants.
REQ-029 The counter table SHALL be the sub-module bht_counter_table (one read port, one saturating-update port, synchronous reset); branch_pred_ctrl holds only the FSM and the redirect logic.

Verification
REQ-030 The bench SHALL cover: after reset, fetch_pc=0x40 -> pred_taken=0; a branch at 0x40 resolved taken twice -> pred_taken=1 for 0x40 and 0x80 (alias at 16 entries).
REQ-031 The bench SHALL cover: a branch at 0x100 with ex_taken=1, ex_pred_taken=0, ex_target=0x200 -> next cycle redirect_valid=1 and redirect_pc=0x200, with flush high 2 cycles.
REQ-032 The bench SHALL cover: ex_taken=0, ex_pred_taken=1, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap-around).
REQ-033 The bench SHALL cover: jal at 0x20 with target 0x80 -> redirect to 0x80 regardless of prediction, with no counter update.
REQ-034 The bench SHALL cover: a mispredict, then a second mispredicting branch in the first FLUSH cycle -> no second redirect and its counter unchanged.
REQ-035 The bench SHALL cover: reset in the 2nd FLUSH cycle -> flush=0 the next cycle and all counters back to 01; a same-index read/update in one cycle returns the old value.
